// File: rtl/aes_subbytes_mc.sv
// Time-multiplexed AES SubBytes engine: LANES bytes through SBOX_COUNT shared
// S-box datapaths per cycle. Forward and inverse modes share one GF(2^8) inverter.
module aes_subbytes_mc #(
  parameter int LANES      = 16,
  parameter int SBOX_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 busy
);

  localparam int NCHUNK = LANES / SBOX_COUNT;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (LANES % SBOX_COUNT != 0) begin : g_bad_cfg
      $error("aes_subbytes_mc: LANES must be a multiple of SBOX_COUNT");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid && ready; valid
  // never depends on ready, and in_ready never depends on in_valid.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           cnt;
  logic                    mode;
  logic [8*LANES-1:0]      data_q;
  logic [8*SBOX_COUNT-1:0] sbox_in, sbox_out;
  logic                    accept, last_chunk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and conveniently maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8];
    return r ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = b[(i+2)%8] ^ b[(i+5)%8] ^ b[(i+7)%8];
    return r ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
    logic [7:0] pre;
    logic [7:0] q;
    pre = inv ? affine_inv(x) : x;
    q   = gf_inv(pre);
    return inv ? q : affine(q);
  endfunction

  always_comb begin
    sbox_in  = '0;
    sbox_out = '0;
    for (int s = 0; s < SBOX_COUNT; s++) begin
      sbox_in[8*s +: 8]  = data_q[8*(int'(cnt)*SBOX_COUNT + s) +: 8];
      sbox_out[8*s +: 8] = sbox(sbox_in[8*s +: 8], mode);
    end
  end

  assign last_chunk = (cnt == CW'(NCHUNK - 1));
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready   = 1'b1;
          state_next = in_valid ? BUSY : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode   <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        data_q <= in_data;
        mode   <= in_inv;
        cnt    <= '0;
      end else if (state == BUSY) begin
        // Results overwrite their own source bytes, so one buffer serves both.
        for (int s = 0; s < SBOX_COUNT; s++)
          data_q[8*(int'(cnt)*SBOX_COUNT + s) +: 8] <= sbox_out[8*s +: 8];
        cnt <= last_chunk ? '0 : cnt + CW'(1);
      end
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign out_data  = data_q;

endmodule
